pixel_coord_gen: RTL and testbench
==================================

Name: pixel_coord_gen

Overview:
Raster-scan pixel coordinate source that drives the ray generator's screen_x / screen_y / coords_valid input. It walks a frame of SCREEN_WIDTH x SCREEN_HEIGHT pixels, left-to-right and then top-to-bottom, with a valid/ready handshake so that downstream ray-marcher stalls apply backpressure. It also emits a linear pixel index and sideband flags so results can be written back to the frame buffer.

Parameters:
SCREEN_WIDTH, `SCREEN_WIDTH (640), pixels per line.
SCREEN_HEIGHT, `SCREEN_HEIGHT (480), lines per frame.
X_W, $clog2(SCREEN_WIDTH), width of the x counter.
Y_W, $clog2(SCREEN_HEIGHT), width of the y counter.
IDX_W, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT), width of the linear index.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
start  in  1  begin a frame; sampled only in IDLE.
continuous  in  1  when 1 at end of frame, restart immediately without a new start.
abort  in  1  synchronous; terminate the frame and return to IDLE.
coords_ready  in  1  downstream accepts the current beat.
screen_x  out  32  fp (Q8.24 container) holding the integer pixel x, zero-extended in the LSBs (not scaled by 2^24).
screen_y  out  32  same format, pixel y.
coords_valid  out  1  beat valid.
pixel_x  out  X_W  integer x.
pixel_y  out  Y_W  integer y.
pixel_idx  out  IDX_W  y*SCREEN_WIDTH + x.
sol  out  1  start of line (x==0), qualified by coords_valid.
eol  out  1  x==SCREEN_WIDTH-1, qualified.
sof  out  1  x==0 and y==0, qualified.
eof  out  1  last pixel of frame, qualified.
busy  out  1  state is RUN.
frame_done  out  1  single-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; all counters and outputs 0; coords_valid 0; busy 0; frame_done 0.
- FSM states are IDLE and RUN. A beat is accepted when coords_valid & coords_ready at a rising edge.
- IDLE: start=1 -> RUN. On that same edge, x=y=idx=0 and coords_valid=1, so the first beat is visible the cycle after start.
- RUN: coords_valid stays 1. While a beat is not accepted, all data and flags hold stable (AXI-style valid/ready rule; valid never drops without acceptance except on abort or reset).
- Accept, not last: x+1. At x==SCREEN_WIDTH-1, x wraps to 0 and y+1. idx+1 in both cases; idx is an incrementing counter, not a multiplier.
- Accept of the last beat (x==W-1, y==H-1):
  - frame_done=1 on the next cycle.
  - If continuous=1 at the accepting edge: stay in RUN; counters go to 0 and coords_valid stays 1 (zero bubble; the sof beat coincides with the frame_done pulse).
  - Otherwise: go to IDLE and coords_valid goes to 0.
- start is ignored in RUN. start and abort both high in IDLE: abort wins and the block stays IDLE.
- abort in RUN: on that edge, go to IDLE, drop coords_valid, and reset counters. frame_done is not pulsed. A beat accepted on the abort edge is counted as consumed.
- Throughput is 1 beat/clk with coords_ready tied to 1. A frame is exactly W*H accepted beats.
- Flags are combinational decodes of the registered counters, ANDed with coords_valid.
- Async reset mid-frame clears everything immediately, with no frame_done.
- screen_x / screen_y equal pixel_x / pixel_y zero-extended to 32 bits; the downstream NDC scaling absorbs the format.

Test Plan:
- Bench parameters W=4, H=3, ready=1, start pulse at cycle 0 -> beats at cycles 1..12.
  - (x,y) sequence (0,0),(1,0)..(3,2); idx 0..11.
  - sof@1, eol@4/8/12, eof@12, frame_done@13.
  - coords_valid=0 @13; busy 1 for cycles 1..12.
- Backpressure: ready low for 3 cycles on beat idx=5 (x=1, y=1) -> outputs hold (1,1,5) for all 3 cycles; the next accepted beat is idx=6; the frame still has exactly 12 beats.
- Continuous=1 -> after eof (3,2) accepted, the next cycle shows (0,0) with sof=1 and frame_done=1, with no valid gap; 24 beats over two frames.
- Abort asserted on the beat at idx=7 -> coords_valid=0 the next cycle; state IDLE; no frame_done; a subsequent start restarts at (0,0).
- Async reset asserted mid-cycle during the beat at idx=4 -> all outputs 0 immediately, without waiting for a clock edge; start after release begins at (0,0).
- Default 640x480, ready=1 -> exactly 307200 beats; eof at (639,479) with idx=307199; frame_done once.

Source files
------------

// File: rtl/pixel_coord_gen.sv
// Raster-scan pixel coordinate source with a valid/ready handshake.
// Walks a SCREEN_WIDTH x SCREEN_HEIGHT frame left-to-right, top-to-bottom,
// and emits integer coordinates, a linear index and line/frame flags.
//
// Handshake: coords_valid/coords_ready. A beat transfers on a rising edge
// where both are high. Once coords_valid is high it stays high, and all
// data and flags stay stable, until the beat transfers. The only exceptions
// are abort and reset, which drop coords_valid without a transfer.

`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

module pixel_coord_gen #(
  parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT,
  parameter int X_W           = $clog2(SCREEN_WIDTH),
  parameter int Y_W           = $clog2(SCREEN_HEIGHT),
  parameter int IDX_W         = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             coords_ready,
  output logic [31:0]      screen_x,
  output logic [31:0]      screen_y,
  output logic             coords_valid,
  output logic [X_W-1:0]   pixel_x,
  output logic [Y_W-1:0]   pixel_y,
  output logic [IDX_W-1:0] pixel_idx,
  output logic             sol,
  output logic             eol,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic             frame_done,
  output logic             dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_HEIGHT - 1);

  state_t           state, state_nxt;
  logic [X_W-1:0]   x_q, x_nxt;
  logic [Y_W-1:0]   y_q, y_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             valid_q, valid_nxt;
  logic             done_q, done_nxt;

  logic accept;
  logic at_eol;
  logic at_last;

  assign accept  = valid_q & coords_ready;
  assign at_eol  = (x_q == X_LAST);
  assign at_last = at_eol & (y_q == Y_LAST);

  // State and counter registers; async reset clears everything, no frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      idx_q   <= idx_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state: start/abort control, raster stepping on accepted beats.
  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    idx_nxt   = idx_q;
    valid_nxt = valid_q;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        // abort has priority over start while idle
        if (!abort && start) begin
          state_nxt = S_RUN;
          x_nxt     = '0;
          y_nxt     = '0;
          idx_nxt   = '0;
          valid_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          // a beat transferring on this edge is simply consumed
          state_nxt = S_IDLE;
          x_nxt     = '0;
          y_nxt     = '0;
          idx_nxt   = '0;
          valid_nxt = 1'b0;
        end else if (accept) begin
          if (at_last) begin
            done_nxt = 1'b1;
            x_nxt    = '0;
            y_nxt    = '0;
            idx_nxt  = '0;
            if (!continuous) begin
              state_nxt = S_IDLE;
              valid_nxt = 1'b0;
            end
          end else if (at_eol) begin
            x_nxt   = '0;
            y_nxt   = y_q + Y_W'(1);
            idx_nxt = idx_q + IDX_W'(1);
          end else begin
            x_nxt   = x_q + X_W'(1);
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Output decode: data straight from counters, flags qualified by valid.
  always_comb begin
    screen_x     = {{(32 - X_W){1'b0}}, x_q};
    screen_y     = {{(32 - Y_W){1'b0}}, y_q};
    pixel_x      = x_q;
    pixel_y      = y_q;
    pixel_idx    = idx_q;
    coords_valid = valid_q;
    sol          = valid_q & (x_q == '0);
    eol          = valid_q & at_eol;
    sof          = valid_q & (x_q == '0) & (y_q == '0);
    eof          = valid_q & at_last;
    busy         = (state == S_RUN);
    frame_done   = done_q;
    dbg_state    = state;
  end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Bench for pixel_coord_gen on a 4x3 frame: directed scenarios then random
// ready/continuous/start/abort traffic, checked against a beat-number model.

module tb_pixel_coord_gen;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int N     = W * H;
  localparam int X_W   = $clog2(W);
  localparam int Y_W   = $clog2(H);
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic             abort = 1'b0;
  logic             coords_ready = 1'b1;
  logic [31:0]      screen_x, screen_y;
  logic             coords_valid;
  logic [X_W-1:0]   pixel_x;
  logic [Y_W-1:0]   pixel_y;
  logic [IDX_W-1:0] pixel_idx;
  logic             sol, eol, sof, eof, busy, frame_done, dbg_state;

  int checks = 0;
  int errors = 0;

  // model: running flag, beat number within the frame, pending done pulse
  bit m_run  = 0;
  int m_n    = 0;
  bit m_done = 0;
  int dut_beats = 0;
  int frames_done = 0;

  pixel_coord_gen #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .abort(abort), .coords_ready(coords_ready),
    .screen_x(screen_x), .screen_y(screen_y), .coords_valid(coords_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_idx(pixel_idx),
    .sol(sol), .eol(eol), .sof(sof), .eof(eof), .busy(busy),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // compare every output against the model's view of the current beat
  task automatic check_all();
    int ex, ey;
    ex = m_run ? (m_n % W) : 0;
    ey = m_run ? (m_n / W) : 0;
    chk("valid", 32'(coords_valid), 32'(m_run));
    chk("busy", 32'(busy), 32'(m_run));
    chk("pixel_x", 32'(pixel_x), 32'(ex));
    chk("pixel_y", 32'(pixel_y), 32'(ey));
    chk("screen_x", screen_x, 32'(ex));
    chk("screen_y", screen_y, 32'(ey));
    chk("pixel_idx", 32'(pixel_idx), m_run ? 32'(m_n) : 32'd0);
    chk("sol", 32'(sol), 32'(m_run && ex == 0));
    chk("eol", 32'(eol), 32'(m_run && ex == W - 1));
    chk("sof", 32'(sof), 32'(m_run && m_n == 0));
    chk("eof", 32'(eof), 32'(m_run && m_n == N - 1));
    chk("frame_done", 32'(frame_done), 32'(m_done));
  endtask

  // one clock: advance the model with the inputs present at the edge, then check
  task automatic tick();
    bit dut_acc;
    @(posedge clk);
    dut_acc = coords_valid && coords_ready;
    m_done = 0;
    if (!m_run) begin
      if (start && !abort) begin
        m_run = 1;
        m_n = 0;
      end
    end else if (abort) begin
      m_run = 0;
      m_n = 0;
    end else if (coords_ready) begin
      if (m_n == N - 1) begin
        m_done = 1;
        m_n = 0;
        m_run = continuous;
      end else begin
        m_n++;
      end
    end
    #1;
    if (dut_acc) dut_beats++;
    if (abort) dut_beats = 0;
    check_all();
    if (frame_done) begin
      frames_done++;
      chk("beats_per_frame", 32'(dut_beats), 32'(N));
      dut_beats = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int guard;
    // reset
    #2;
    chk("reset_valid", 32'(coords_valid), 32'd0);
    chk("reset_idx", 32'(pixel_idx), 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    tick();
    tick();

    // plain frame, ready tied high
    pulse_start();
    repeat (N) tick();
    chk("frames_after_first", 32'(frames_done), 32'd1);
    tick();

    // backpressure on idx 5
    pulse_start();
    guard = 0;
    while (m_n != 5 && guard < 50) begin tick(); guard++; end
    chk("reach_idx5", 32'(m_n), 32'd5);
    coords_ready = 1'b0;
    repeat (3) tick();
    coords_ready = 1'b1;
    guard = 0;
    while (m_run && guard < 50) begin tick(); guard++; end
    chk("frames_after_bp", 32'(frames_done), 32'd2);

    // continuous: two back-to-back frames
    continuous = 1'b1;
    pulse_start();
    repeat (N - 1) tick();
    tick();
    continuous = 1'b0;
    repeat (N) tick();
    chk("frames_after_cont", 32'(frames_done), 32'd4);
    tick();

    // abort on idx 7
    pulse_start();
    guard = 0;
    while (m_n != 7 && guard < 50) begin tick(); guard++; end
    chk("reach_idx7", 32'(m_n), 32'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    // start with abort while idle stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    chk("frames_after_abort", 32'(frames_done), 32'd4);
    pulse_start();

    // async reset during idx 4
    guard = 0;
    while (m_n != 4 && guard < 50) begin tick(); guard++; end
    #2;
    rst = 1'b0;
    #1;
    m_run = 0; m_n = 0; m_done = 0; dut_beats = 0;
    check_all();
    #2;
    rst = 1'b1;
    tick();
    pulse_start();
    repeat (3) tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      coords_ready = ($urandom_range(0, 3) != 0);
      continuous   = ($urandom_range(0, 1) == 1);
      start        = ($urandom_range(0, 4) == 0);
      abort        = ($urandom_range(0, 39) == 0);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    continuous = 1'b0;
    coords_ready = 1'b1;
    guard = 0;
    while (m_run && guard < 50) begin tick(); guard++; end
    chk("drained", 32'(coords_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
